// File: rtl/vga_pkg.sv
// Shared VGA definitions used by the timing generator and the sync receiver.
// Holds the receiver state enum and the default 640x480 timing constants.
// Contents:
//   sync_state_e  - SEARCH / ACQUIRE / LOCK receiver states
//   VGA_*         - default horizontal/vertical timing and lock qualification
package vga_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCK    = 2'd2
  } sync_state_e;

  localparam int unsigned VGA_W           = 640;
  localparam int unsigned VGA_H           = 480;
  localparam int unsigned VGA_HBP         = 16;
  localparam int unsigned VGA_HSYNC       = 96;
  localparam int unsigned VGA_HFP         = 48;
  localparam int unsigned VGA_VBP         = 11;
  localparam int unsigned VGA_VSYNC       = 2;
  localparam int unsigned VGA_VFP         = 31;
  localparam int unsigned VGA_LOCK_FRAMES = 2;

endpackage

// File: rtl/vga_sync_rx_sync_edge.sv
// sync_edge: single input register plus edge detection for an active-low
// sync line. The register resets high (sync deasserted) so a line that is
// already low when reset releases is reported as a fall.
// Ports:
//   CLK  - pixel clock
//   RST  - synchronous active-high reset
//   din  - raw sync input
//   fall - registered value high, current input low
//   rise - registered value low, current input high
module sync_edge (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic fall,
  output logic rise
);

  logic q;

  // One register stage; edges compare it against the live input.
  always_ff @(posedge CLK) begin
    if (RST) q <= 1'b1;
    else     q <= din;
  end

  assign fall = q & ~din;
  assign rise = ~q & din;

endmodule

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: VGA timing receiver. Realigns local X/Y counters to incoming
// HS_/VS_, checks the stream against the configured timing and reports lock.
// X/Y/HB/VB describe the pixel whose syncs were presented one edge earlier.
// Optional feature macro: VGA_SYNC_RX_MEASURE_EN adds HTOT/VTOT measurement.
// Ports:
//   CLK, RST      - pixel clock, synchronous active-high reset
//   HS_, VS_      - incoming active-low syncs
//   X, Y          - recovered column / row
//   HB, VB        - blanking (outside active area or not locked)
//   LOCKED        - stream matches configured timing
//   ERR           - one-cycle pulse on a timing violation
//   HTOT, VTOT    - (measure build) cycles per line, lines per frame
module vga_sync_rx
  import vga_pkg::*;
#(
  parameter int unsigned W           = VGA_W,
  parameter int unsigned H           = VGA_H,
  parameter int unsigned Hbp         = VGA_HBP,
  parameter int unsigned Hsync       = VGA_HSYNC,
  parameter int unsigned Hfp         = VGA_HFP,
  parameter int unsigned Vbp         = VGA_VBP,
  parameter int unsigned Vsync       = VGA_VSYNC,
  parameter int unsigned Vfp         = VGA_VFP,
  parameter int unsigned LOCK_FRAMES = VGA_LOCK_FRAMES,
  localparam int unsigned HT = W + Hbp + Hsync + Hfp,
  localparam int unsigned VT = H + Vbp + Vsync + Vfp,
  localparam int unsigned XW = $clog2(HT),
  localparam int unsigned YW = $clog2(VT)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          HS_,
  input  logic          VS_,
  output logic [XW-1:0] X,
  output logic [YW-1:0] Y,
  output logic          HB,
  output logic          VB,
  output logic          LOCKED,
`ifdef VGA_SYNC_RX_MEASURE_EN
  output logic [XW:0]   HTOT,
  output logic [YW:0]   VTOT,
`endif
  output logic          ERR
);

  localparam int unsigned FW = $clog2(LOCK_FRAMES + 1);

  localparam logic [XW-1:0] X_ACT     = XW'(W);
  localparam logic [XW-1:0] X_HS_FALL = XW'(W + Hbp);
  localparam logic [XW-1:0] X_HS_RISE = XW'(W + Hbp + Hsync);
  localparam logic [XW-1:0] X_LAST    = XW'(HT - 1);
  localparam logic [YW-1:0] Y_ACT     = YW'(H);
  localparam logic [YW-1:0] Y_VS_FALL = YW'(H + Vbp);
  localparam logic [YW-1:0] Y_VS_RISE = YW'(H + Vbp + Vsync);
  localparam logic [YW-1:0] Y_LAST    = YW'(VT - 1);
  localparam logic [FW-1:0] FC_LAST   = FW'(LOCK_FRAMES - 1);

  logic hs_fall, hs_rise, vs_fall, vs_rise;

  sync_edge u_hs_edge (
    .CLK  (CLK),
    .RST  (RST),
    .din  (HS_),
    .fall (hs_fall),
    .rise (hs_rise)
  );

  sync_edge u_vs_edge (
    .CLK  (CLK),
    .RST  (RST),
    .din  (VS_),
    .fall (vs_fall),
    .rise (vs_rise)
  );

  sync_state_e   state, state_d;
  logic [XW-1:0] x, x_d, x_inc;
  logic [YW-1:0] y, y_d, y_inc;
  logic [FW-1:0] frame_cnt, frame_cnt_d;
  logic          err;
  logic          hs_bad, vs_bad, violation;

  // State and counter registers; ERR is the registered violation flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= SEARCH;
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      x         <= x_d;
      y         <= y_d;
      frame_cnt <= frame_cnt_d;
      err       <= violation;
    end
  end

  // Next-state logic. x_inc/y_inc are the position of the pixel whose syncs
  // are being sampled on this edge, so all checks compare against them.
  // A violation is handled exactly like a SEARCH edge, which means a
  // misplaced VS_ fall immediately re-enters ACQUIRE aligned to itself.
  // Checks are masked for the cycle after an ERR so it can never repeat.
  always_comb begin
    x_inc = (x == X_LAST) ? '0 : x + 1'b1;
    y_inc = y;
    if (x == X_LAST) y_inc = (y == Y_LAST) ? '0 : y + 1'b1;

    hs_bad = (hs_fall && (x_inc != X_HS_FALL)) ||
             ((x_inc == X_HS_FALL) && HS_)     ||
             (hs_rise && (x_inc != X_HS_RISE));
    vs_bad = (vs_fall && !((y_inc == Y_VS_FALL) && (x_inc == '0))) ||
             (vs_rise && !((y_inc == Y_VS_RISE) && (x_inc == '0)));
    violation = (state != SEARCH) && !err && (hs_bad || vs_bad);

    state_d     = state;
    x_d         = x_inc;
    y_d         = y_inc;
    frame_cnt_d = frame_cnt;

    if ((state == SEARCH) || violation) begin
      state_d = SEARCH;
      y_d     = '0;
      if (hs_fall) x_d = X_HS_FALL;
      if (vs_fall) begin
        state_d     = ACQUIRE;
        frame_cnt_d = '0;
        y_d         = Y_VS_FALL;
        x_d         = hs_fall ? X_HS_FALL : '0;
      end
    end else if ((state == ACQUIRE) && vs_fall) begin
      if (frame_cnt == FC_LAST) state_d = LOCK;
      else                      frame_cnt_d = frame_cnt + 1'b1;
    end
  end

  assign X      = x;
  assign Y      = y;
  assign LOCKED = (state == LOCK);
  assign HB     = !LOCKED || (x >= X_ACT);
  assign VB     = !LOCKED || (y >= Y_ACT);
  assign ERR    = err;

`ifdef VGA_SYNC_RX_MEASURE_EN
  logic [XW:0] hcnt, htot;
  logic [YW:0] vcnt, vtot;

  // Line length in cycles and frame length in HS_ falls, taken between the
  // last two falls regardless of lock state. A coincident HS_ fall belongs
  // to the frame that starts on that VS_ fall.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hcnt <= '0;
      htot <= '0;
      vcnt <= '0;
      vtot <= '0;
    end else begin
      if (hs_fall) begin
        hcnt <= '0;
        htot <= (&hcnt) ? hcnt : hcnt + 1'b1;
      end else if (!(&hcnt)) begin
        hcnt <= hcnt + 1'b1;
      end
      if (vs_fall) begin
        vtot <= vcnt;
        vcnt <= hs_fall ? (YW+1)'(1) : '0;
      end else if (hs_fall && !(&vcnt)) begin
        vcnt <= vcnt + 1'b1;
      end
    end
  end

  assign HTOT = htot;
  assign VTOT = vtot;
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// Testbench for vga_sync_rx using a reduced timing (16 x 8 total) so whole
// frames are short. A table of reset/SEARCH vectors is followed by
// generator-driven sequences for lock, shifted sync, missing sync, short
// sync pulse and mid-frame reset.
module tb_vga_sync_rx;

  localparam int TW = 8, TH = 4;
  localparam int THBP = 2, THS = 3, THFP = 3;
  localparam int TVBP = 1, TVS = 1, TVFP = 2;
  localparam int TLF = 2;
  localparam int HT = TW + THBP + THS + THFP;
  localparam int VT = TH + TVBP + TVS + TVFP;
  localparam int FRAME = HT * VT;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       HS_ = 1'b1;
  logic       VS_ = 1'b1;
  logic [3:0] X;
  logic [2:0] Y;
  logic       HB, VB, LOCKED, ERR;
`ifdef VGA_SYNC_RX_MEASURE_EN
  logic [4:0] htot;
  logic [3:0] vtot;
`endif

  vga_sync_rx #(
    .W(TW), .H(TH), .Hbp(THBP), .Hsync(THS), .Hfp(THFP),
    .Vbp(TVBP), .Vsync(TVS), .Vfp(TVFP), .LOCK_FRAMES(TLF)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .HS_    (HS_),
    .VS_    (VS_),
    .X      (X),
    .Y      (Y),
    .HB     (HB),
    .VB     (VB),
    .LOCKED (LOCKED),
`ifdef VGA_SYNC_RX_MEASURE_EN
    .HTOT   (htot),
    .VTOT   (vtot),
`endif
    .ERR    (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] x;
    logic [2:0] y;
    logic       hb;
    logic       vb;
    logic       locked;
    logic       err;
  } outs_t;

  typedef struct {
    logic  rst;
    logic  hs;
    logic  vs;
    outs_t exp;
  } vec_t;

  int compared   = 0;
  int mismatched = 0;
  int gx = 0, gy = 0;
  int err_seen = 0, xy_bad = 0;
  vec_t vecs[17];

  function automatic vec_t mk_vec(input logic rst, hs, vs, input int x, y,
                                  input logic err);
    vec_t v;
    v.rst = rst;
    v.hs  = hs;
    v.vs  = vs;
    v.exp = {4'(x), 3'(y), 1'b1, 1'b1, 1'b0, err};
    return v;
  endfunction

  // Reference generator: HS_ low for pixels 10..12, VS_ low for line 5.
  function automatic logic gen_hs();
    return !((gx >= TW + THBP) && (gx < TW + THBP + THS));
  endfunction

  function automatic logic gen_vs();
    return !((gy >= TH + TVBP) && (gy < TH + TVBP + TVS));
  endfunction

  function automatic int cycles_to(input int tx, input int ty);
    return ((ty * HT + tx) - (gy * HT + gx) + FRAME) % FRAME;
  endfunction

  task automatic advance_gen();
    gx = gx + 1;
    if (gx == HT) begin
      gx = 0;
      gy = (gy + 1) % VT;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic hs, input logic vs);
    RST = rst;
    HS_ = hs;
    VS_ = vs;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = {X, Y, HB, VB, LOCKED, ERR};
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got x=%0d y=%0d hb=%b vb=%b locked=%b err=%b, want x=%0d y=%0d hb=%b vb=%b locked=%b err=%b",
               name, act.x, act.y, act.hb, act.vb, act.locked, act.err,
               exp.x, exp.y, exp.hb, exp.vb, exp.locked, exp.err);
    end
  endtask

  task automatic check_value(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Clean generator cycles; X/Y/HB/VB are tracked whenever LOCKED is high.
  task automatic gen_run(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, gen_hs(), gen_vs());
      if (ERR) err_seen++;
      if (LOCKED && ((X !== 4'(gx)) || (Y !== 3'(gy)) ||
                     (HB !== (gx >= TW)) || (VB !== (gy >= TH))))
        xy_bad++;
      advance_gen();
    end
  endtask

  // From SEARCH: next VS_ fall enters ACQUIRE, lock comes exactly two
  // frames later on the edge registering the second clean VS_ fall.
  task automatic relock_check(input string tag);
    gen_run(cycles_to(0, TH + TVBP));
    gen_run(1);
    check_value({tag, "_acquire_unlocked"}, int'(LOCKED), 0);
    gen_run(2 * FRAME - 1);
    check_value({tag, "_prelock"}, int'(LOCKED), 0);
    gen_run(1);
    check_value({tag, "_lock"}, int'(LOCKED), 1);
  endtask

  initial begin
    // Reset, SEARCH reloads, ACQUIRE entry and early-fall / early-rise errors.
    vecs[0]  = mk_vec(1, 1, 1, 0, 0, 0);
    vecs[1]  = mk_vec(0, 1, 1, 1, 0, 0);
    vecs[2]  = mk_vec(0, 1, 1, 2, 0, 0);
    vecs[3]  = mk_vec(0, 0, 1, 10, 0, 0);
    vecs[4]  = mk_vec(0, 0, 1, 11, 0, 0);
    vecs[5]  = mk_vec(0, 1, 1, 12, 0, 0);
    vecs[6]  = mk_vec(0, 0, 1, 10, 0, 0);
    vecs[7]  = mk_vec(0, 1, 1, 11, 0, 0);
    vecs[8]  = mk_vec(0, 1, 0, 0, 5, 0);
    vecs[9]  = mk_vec(0, 1, 0, 1, 5, 0);
    vecs[10] = mk_vec(0, 0, 0, 10, 0, 1);
    vecs[11] = mk_vec(0, 0, 0, 11, 0, 0);
    vecs[12] = mk_vec(0, 1, 1, 12, 0, 0);
    vecs[13] = mk_vec(0, 0, 0, 10, 5, 0);
    vecs[14] = mk_vec(0, 0, 0, 11, 5, 0);
    vecs[15] = mk_vec(0, 1, 0, 12, 0, 1);
    vecs[16] = mk_vec(0, 1, 1, 13, 0, 0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].hs, vecs[i].vs);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Fresh reset, then lock onto the reference generator.
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("reset", {4'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0});
`ifdef VGA_SYNC_RX_MEASURE_EN
    check_value("reset_htot", int'(htot), 0);
    check_value("reset_vtot", int'(vtot), 0);
`endif
    gx = 0;
    gy = 0;
    err_seen = 0;
    xy_bad = 0;
    relock_check("init");
    gen_run(4 * FRAME);
    check_value("run_locked", int'(LOCKED), 1);
    check_value("run_err_count", err_seen, 0);
    check_value("run_xy_bad", xy_bad, 0);
`ifdef VGA_SYNC_RX_MEASURE_EN
    check_value("run_htot", int'(htot), HT);
    check_value("run_vtot", int'(vtot), VT);
`endif

    // HS_ fall delayed by one pixel: missing sync at 10, then reload at 11.
    gen_run(cycles_to(TW + THBP, 2));
    applyStimulus(1'b0, 1'b1, gen_vs());
    checkOutput("shift_err", {4'd10, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1});
    advance_gen();
    applyStimulus(1'b0, gen_hs(), gen_vs());
    checkOutput("shift_reload", {4'd10, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    advance_gen();
    err_seen = 0;
    relock_check("shift");
    check_value("shift_err_after", err_seen, 0);

    // Suppressed HS_ pulse on line 1.
    gen_run(cycles_to(TW + THBP, 1));
    applyStimulus(1'b0, 1'b1, gen_vs());
    checkOutput("miss_err", {4'd10, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1});
    advance_gen();
    applyStimulus(1'b0, 1'b1, gen_vs());
    advance_gen();
    applyStimulus(1'b0, 1'b1, gen_vs());
    checkOutput("miss_search", {4'd12, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    advance_gen();
    relock_check("miss");

    // HS_ pulse one pixel short: rise arrives at 12 instead of 13.
    gen_run(cycles_to(TW + THBP + THS - 1, 2));
    applyStimulus(1'b0, 1'b1, gen_vs());
    checkOutput("narrow_err", {4'd12, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1});
    advance_gen();
    relock_check("narrow");

    // Reset while locked, mid-frame.
    gen_run(cycles_to(3, 2));
    applyStimulus(1'b1, gen_hs(), gen_vs());
    checkOutput("midframe_reset", {4'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    advance_gen();
    relock_check("rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_sync_rx.md
# vga_sync_rx

Video timing receiver for the VGA output path: the sink-side counterpart of the VGA timing generator. Samples incoming active-low HS_/VS_ in the pixel-clock domain, realigns local X/Y counters to the incoming stream, checks the stream against the configured timing, and reports lock. Used by capture and loopback paths that must know which pixel an incoming sample belongs to.

## Interface

Parameters:
- W, 640, active pixels per line
- H, 480, active lines per frame
- Hbp, 16, pixels from end of active to HS_ assertion
- Hsync, 96, HS_ low width in pixels
- Hfp, 48, pixels from HS_ deassertion to line end
- Vbp, 11, lines from end of active to VS_ assertion
- Vsync, 2, VS_ low width in lines
- Vfp, 31, lines from VS_ deassertion to frame end
- LOCK_FRAMES, 2, consecutive clean frames required to assert LOCKED (≥1)

Ports:
- CLK  in  1  pixel clock
- RST  in  1  reset; synchronous, active-high
- HS_  in  1  incoming horizontal sync, active low
- VS_  in  1  incoming vertical sync, active low
- X  out  XW = $clog2(W+Hbp+Hsync+Hfp)  recovered column
- Y  out  YW = $clog2(H+Vbp+Vsync+Vfp)  recovered row
- HB  out  1  horizontal blank (X ≥ W, or not LOCKED)
- VB  out  1  vertical blank (Y ≥ H, or not LOCKED)
- LOCKED  out  1  stream matches configured timing
- ERR  out  1  one-cycle pulse on any timing violation

## Operation

- Inputs registered once (hs_q, vs_q); fall = q high and input low; rise = q low and input high.
- HT = W+Hbp+Hsync+Hfp, VT = H+Vbp+Vsync+Vfp. X counts 0..HT-1; at HT-1 wraps to 0 and Y increments, Y wraps at VT-1.
- State machine SEARCH → ACQUIRE → LOCK:
  - SEARCH: X free-runs; every HS_ fall loads X ← W+Hbp; Y held 0. VS_ fall loads Y ← H+Vbp, X ← W+Hbp (if coincident with HS_ fall) else X ← 0; enter ACQUIRE, frame counter ← 0.
  - ACQUIRE/LOCK: counters free-run, no reloading. Checks, each a violation on failure:
    - HS_ fall only when X = W+Hbp; HS_ sampled low at X = W+Hbp (missing sync).
    - HS_ rise only when X = W+Hbp+Hsync.
    - VS_ fall only when Y = H+Vbp at X = 0; VS_ rise only when Y = H+Vbp+Vsync at X = 0.
  - Violation: ERR pulses 1 cycle, state → SEARCH, LOCKED ← 0 on same edge; the violating edge is processed as a SEARCH edge (reload applies immediately).
  - ACQUIRE: frame counter increments at each clean VS_ fall; reaching LOCK_FRAMES → LOCK.
  - LOCK: stays until violation or RST.
- HB/VB forced 1 outside LOCK.

## Timing

- Latency: X/Y/HB/VB describe the pixel whose HS_/VS_ values were presented one CLK edge earlier (one input register stage).
- RST: X=0, Y=0, HB=1, VB=1, LOCKED=0, ERR=0, state SEARCH, hs_q=vs_q=1. RST mid-frame discards lock immediately.
- LOCKED rises on the edge that registers the LOCK_FRAMES-th clean VS_ fall after entering ACQUIRE; with defaults, 2 frames after the first VS_ fall.
- ERR never asserted in SEARCH; never two consecutive cycles.
- HS_/VS_ simultaneous falls (generator aligns them at X = W+Hbp only if the line wraps there; normally VS_ changes at X = 0): both checks evaluated independently in the same cycle.

## Configuration

- VGA_SYNC_RX_MEASURE_EN defined: adds outputs HTOT (XW+1 bits, cycles between last two HS_ falls) and VTOT (YW+1 bits, HS_ falls between last two VS_ falls), updated every sync fall in any state, saturating at all-ones, reset 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure

- Shared package vga_pkg: state enum (SEARCH, ACQUIRE, LOCK) and default timing constants, shared with the timing generator.
- One sub-module: sync_edge (input register + rise/fall detect), instanced for HS_ and VS_.

## Test plan

- Drive from the VGA timing generator, defaults: after RST, LOCKED=1 after two VS_ falls; X/Y equal generator X/Y delayed one cycle thereafter, ERR never pulses over 4 frames.
- Start stream mid-frame (generator reset 1000 cycles after receiver): no ERR, lock after 2 full frames.
- Shift one HS_ fall by +1 pixel while locked: ERR pulse, LOCKED=0 next edge, X reloaded to 656, relock 2 frames later.
- Suppress one HS_ pulse: ERR at X=656 of that line, state SEARCH.
- Hsync width 95 instead of 96: ERR at the early rise.
- Assert RST mid-frame while locked: all outputs at reset values next edge; with VGA_SYNC_RX_MEASURE_EN, HTOT=800, VTOT=524 after one frame.
